// File: rtl/csr_regfile_pkg.sv
// Shared CSR definitions: CSR numbers, writable-bit masks, ESTAT layout, exception codes.
// The timer CSRs exist only when CSR_TIMER_EN is defined.
package csr_regfile_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [31:0] CRMD_WMASK   = 32'h0000_001f;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1bff;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hffff_ffc0;
  localparam logic [31:0] CRMD_RST     = 32'h0000_0008;

  typedef enum logic [5:0] {
    ECODE_INT = 6'h00,
    ECODE_ADE = 6'h08,
    ECODE_ALE = 6'h09,
    ECODE_SYS = 6'h0b,
    ECODE_BRK = 6'h0c,
    ECODE_INE = 6'h0d
  } ecode_e;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  typedef struct packed {
    logic       rsvd31;
    logic [8:0] esubcode;
    logic [5:0] ecode;
    logic [2:0] rsvd15;
    logic       ipi;
    logic       timer;
    logic       rsvd10;
    logic [7:0] hw;
    logic [1:0] sw;
  } estat_t;

  function automatic logic [31:0] csr_merge(input logic [31:0] old, input logic [31:0] wval,
                                            input logic [31:0] wmask, input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old & ~m) | (wval & m);
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Pipeline-side CSR bundle: read/write port, writeback exception/ertn commit, interrupts, fetch PCs.
// The writeback stage drives it as master; csr_regfile is the slave.
interface csr_regfile_if;
  import csr_regfile_pkg::*;

  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wval;
  logic        wb_exc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        badv_is_pc;
  logic        badv_is_mem;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic [1:0]  crmd_plv;
  logic        crmd_da;

  modport master (
    output csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
           wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_badvaddr, badv_is_pc, badv_is_mem,
           ertn_flush, hw_int_in, ipi_int_in,
    input  csr_rvalue, has_int, ex_entry, ertn_pc, crmd_plv, crmd_da
  );

  modport slave (
    input  csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
           wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_badvaddr, badv_is_pc, badv_is_mem,
           ertn_flush, hw_int_in, ipi_int_in,
    output csr_rvalue, has_int, ex_entry, ertn_pc, crmd_plv, crmd_da
  );

endinterface

// File: rtl/csr_regfile_timer.sv
// csr_timer: TCFG/TVAL constant timer with one-shot or periodic reload and a one-cycle expiry flag.
// TCFG writes take effect at the next posedge; no backpressure.
module csr_timer
  import csr_regfile_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] wmask,
  input  logic [TIMER_W-1:0] wval,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               expire
);
  logic               timer_en;
  logic [TIMER_W-1:0] tcfg_new;

  assign tcfg_new = (tcfg & ~wmask) | (wval & wmask);
  assign expire   = timer_en && (tval == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg     <= '0;
      tval     <= '1;
      timer_en <= 1'b0;
    end else if (tcfg_we) begin
      // A configuration write overrides any same-cycle expiry reload.
      tcfg     <= tcfg_new;
      timer_en <= tcfg_new[0];
      if (tcfg_new[0]) tval <= {tcfg_new[TIMER_W-1:2], 2'b00};
    end else if (timer_en) begin
      if (tval != '0) begin
        tval <= tval - 1'b1;
      end else if (tcfg[1]) begin
        tval <= {tcfg[TIMER_W-1:2], 2'b00};
      end else begin
        tval     <= '1;
        timer_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch CSR file with exception/ertn updates and interrupt pending; reads are combinational.
// State updates at the posedge after the strobe, no backpressure; CSR_TIMER_EN adds TCFG/TVAL/TICLR.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input logic          clk,
  input logic          resetn,
  csr_regfile_if.slave bus
);
  logic [31:0]      crmd, prmd, ecfg, era, badv, eentry, tid;
  logic [31:0]      crmd_n, prmd_n, ecfg_n, era_n, badv_n, eentry_n, tid_n;
  logic [3:0][31:0] save, save_n;
  estat_t           estat, estat_n;
  logic [31:0]      estat_bits;
  logic [31:0]      tcfg_rd, tval_rd;
  logic             timer_is_n;

  assign estat_bits = estat;

`ifdef CSR_TIMER_EN
  logic [TIMER_W-1:0] tcfg, tval;
  logic               timer_expire, ticlr_clr;

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .tcfg_we (bus.csr_we && (bus.csr_wnum == CSR_TCFG)),
    .wmask   (bus.csr_wmask[TIMER_W-1:0]),
    .wval    (bus.csr_wval[TIMER_W-1:0]),
    .tcfg    (tcfg),
    .tval    (tval),
    .expire  (timer_expire)
  );

  assign ticlr_clr  = bus.csr_we && (bus.csr_wnum == CSR_TICLR) && bus.csr_wmask[0] && bus.csr_wval[0];
  assign tcfg_rd    = 32'(tcfg);
  assign tval_rd    = 32'(tval);
  // Expiry outranks a same-cycle TICLR so a tick is never lost.
  assign timer_is_n = timer_expire | (estat.timer & ~ticlr_clr);
`else
  assign tcfg_rd    = '0;
  assign tval_rd    = '0;
  assign timer_is_n = 1'b0;
`endif

  // Later assignments win: exception over ertn over software write, field by field.
  always_comb begin
    crmd_n   = crmd;
    prmd_n   = prmd;
    ecfg_n   = ecfg;
    estat_n  = estat;
    era_n    = era;
    badv_n   = badv;
    eentry_n = eentry;
    tid_n    = tid;
    save_n   = save;
    if (bus.csr_we) begin
      case (bus.csr_wnum)
        CSR_CRMD:   crmd_n   = csr_merge(crmd, bus.csr_wval, bus.csr_wmask, CRMD_WMASK);
        CSR_PRMD:   prmd_n   = csr_merge(prmd, bus.csr_wval, bus.csr_wmask, PRMD_WMASK);
        CSR_ECFG:   ecfg_n   = csr_merge(ecfg, bus.csr_wval, bus.csr_wmask, ECFG_WMASK);
        CSR_ESTAT:  estat_n  = estat_t'(csr_merge(estat_bits, bus.csr_wval, bus.csr_wmask, ESTAT_WMASK));
        CSR_ERA:    era_n    = csr_merge(era, bus.csr_wval, bus.csr_wmask, '1);
        CSR_BADV:   badv_n   = csr_merge(badv, bus.csr_wval, bus.csr_wmask, '1);
        CSR_EENTRY: eentry_n = csr_merge(eentry, bus.csr_wval, bus.csr_wmask, EENTRY_WMASK);
        CSR_SAVE0:  save_n[0] = csr_merge(save[0], bus.csr_wval, bus.csr_wmask, '1);
        CSR_SAVE1:  save_n[1] = csr_merge(save[1], bus.csr_wval, bus.csr_wmask, '1);
        CSR_SAVE2:  save_n[2] = csr_merge(save[2], bus.csr_wval, bus.csr_wmask, '1);
        CSR_SAVE3:  save_n[3] = csr_merge(save[3], bus.csr_wval, bus.csr_wmask, '1);
        CSR_TID:    tid_n    = csr_merge(tid, bus.csr_wval, bus.csr_wmask, '1);
        default: ;
      endcase
    end
    estat_n.hw    = bus.hw_int_in;
    estat_n.ipi   = bus.ipi_int_in;
    estat_n.timer = timer_is_n;
    if (bus.ertn_flush) crmd_n[2:0] = prmd[2:0];
    if (bus.wb_exc) begin
      prmd_n[2:0]      = crmd[2:0];
      crmd_n[2:0]      = 3'b000;
      estat_n.ecode    = bus.wb_ecode;
      estat_n.esubcode = bus.wb_esubcode;
      era_n            = bus.wb_pc;
      if (bus.badv_is_pc)       badv_n = bus.wb_pc;
      else if (bus.badv_is_mem) badv_n = bus.wb_badvaddr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd   <= CRMD_RST;
      prmd   <= '0;
      ecfg   <= '0;
      estat  <= '0;
      era    <= '0;
      badv   <= '0;
      eentry <= '0;
      tid    <= '0;
      save   <= '0;
    end else begin
      crmd   <= crmd_n;
      prmd   <= prmd_n;
      ecfg   <= ecfg_n;
      estat  <= estat_n;
      era    <= era_n;
      badv   <= badv_n;
      eentry <= eentry_n;
      tid    <= tid_n;
      save   <= save_n;
    end
  end

  always_comb begin
    bus.csr_rvalue = '0;
    case (bus.csr_rnum)
      CSR_CRMD:   bus.csr_rvalue = crmd;
      CSR_PRMD:   bus.csr_rvalue = prmd;
      CSR_ECFG:   bus.csr_rvalue = ecfg;
      CSR_ESTAT:  bus.csr_rvalue = estat_bits;
      CSR_ERA:    bus.csr_rvalue = era;
      CSR_BADV:   bus.csr_rvalue = badv;
      CSR_EENTRY: bus.csr_rvalue = eentry;
      CSR_SAVE0:  bus.csr_rvalue = save[0];
      CSR_SAVE1:  bus.csr_rvalue = save[1];
      CSR_SAVE2:  bus.csr_rvalue = save[2];
      CSR_SAVE3:  bus.csr_rvalue = save[3];
      CSR_TID:    bus.csr_rvalue = tid;
      CSR_TCFG:   bus.csr_rvalue = tcfg_rd;
      CSR_TVAL:   bus.csr_rvalue = tval_rd;
      default: ;
    endcase
  end

  assign bus.has_int  = crmd[2] & (|(estat_bits[12:0] & ecfg[12:0]));
  assign bus.ex_entry = eentry;
  assign bus.ertn_pc  = era;
  assign bus.crmd_plv = crmd[1:0];
  assign bus.crmd_da  = crmd[3];

endmodule
